alu_issue: RTL and testbench
============================

# alu_issue

Issue and writeback sequencer for the ALU. Accepts one RV32I ALU-class instruction and its operand values through a valid/ready handshake, decodes it into `a`, `b` and `alu_op_select`, and strobes the ALU's `clk_enable` for exactly one cycle. It then captures the registered ALU result and presents it to writeback through a second valid/ready handshake. It sits between the decode/register-read stage and the ALU.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: block can accept.
- `instr` in 32: instruction word.
- `pc` in 32: instruction address, used by AUIPC.
- `rs1_data`, `rs2_data` in 32: operand register values, sampled with `instr`.
- `alu_clk_enable` out 1: drives the ALU `clk_enable`.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_op_select` out 4: ALU operation code.
- `alu_out` in 32: registered ALU result.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepts.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.
- `illegal_instr` out 1: one-cycle pulse for an undecodable instruction.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, WB, ERR. `instr_ready` = (state == IDLE).
- Accept happens in IDLE when `instr_valid && instr_ready`:
  - Legal instruction: load `alu_a`, `alu_b`, `alu_op_select`, `wb_rd` and go to ISSUE.
  - Illegal instruction: go to ERR. Nothing else changes.
- ISSUE: `alu_clk_enable` = 1. Go to CAPTURE. `alu_clk_enable` is 0 in every other state.
- CAPTURE: `wb_data` <= `alu_out`. Go to WB.
- WB: `wb_valid` = 1. When `wb_ready` is high, go to IDLE. Otherwise hold, with all outputs stable.
- ERR: `illegal_instr` = 1. Go to IDLE.
- ALU operation codes: ADD 0, SUB 1, SLT 2, SLTU 3, XOR 4, OR 5, AND 6, SLL 7, SRL 8, SRA 9.
- OP (0110011): `a` = rs1, `b` = rs2.
  - funct3 maps 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - funct7 0100000 is legal only with funct3 000 (SUB) and 101 (SRA). funct7 0000000 is legal with every funct3. Any other funct7 is illegal.
- OP-IMM (0010011): `a` = rs1, `b` = sign-extended `instr[31:20]`.
  - Shifts (funct3 001/101): `b` = {27'b0, `instr[24:20]`}.
  - `instr[31:25]` must be 0000000 (SLLI, SRLI) or 0100000 (SRAI only). Any other value is illegal.
  - SUB is never produced from OP-IMM.
- Any other opcode is illegal.
- `rd` = x0 is executed normally with `wb_rd` = 0. Writeback discards the result.
- `alu_a`, `alu_b` and `alu_op_select` stay stable from accept until the next accept.

## Timing
- All outputs are 0 at reset. State resets to IDLE, so `instr_ready` is 1 immediately after reset release.
- Accept on the edge ending cycle T gives this sequence:
  - ISSUE in T+1 (ALU registers its result at the end of T+1).
  - CAPTURE in T+2.
  - `wb_valid` high from T+3.
- With `wb_ready` held high, `instr_ready` returns at T+4. Maximum throughput is one instruction per 4 cycles.
- Illegal instruction: `illegal_instr` is high in T+1 only, `instr_ready` is high at T+2, and `wb_valid` is never asserted.
- A `wb_valid`/`wb_ready` transfer happens on the edge where both are high. `wb_valid` drops in the next cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. The in-flight instruction is lost.

## Configuration
- `ALU_ISSUE_UTYPE_EN`:
  - Defined: LUI (0110111) is legal with `a` = 0, `b` = {`instr[31:12]`, 12'b0}, op ADD. AUIPC (0010111) is legal with `a` = `pc`, same `b`, op ADD.
  - Undefined: both opcodes are illegal, and `pc` is unused.

## Structure
- Package `alu_pkg` holds:
  - `alu_ops_e`, which moves out of the ALU so both blocks share it.
  - Opcode and funct7 localparams.
  - The FSM state enum.
- Sub-module `alu_instr_decode`: purely combinational. It maps `instr`, `pc`, `rs1_data`, `rs2_data` to operands, op, rd and an illegal flag. `alu_issue` holds the FSM and registers.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7 -> op 0, a = 5, b = 7. At T+3: `wb_valid`, `wb_rd` = 3, `wb_data` = 12.
- SUB (0x402081B3), rs1 = 5, rs2 = 7 -> op 1, `wb_data` = 0xFFFFFFFE.
- SRAI x5,x6,4 (0x40435293), rs1 = 0x80000000 -> op 9, b = 4, `wb_rd` = 5, `wb_data` = 0xF8000000.
- Instruction 0x0000007F -> `illegal_instr` pulse in T+1, no `wb_valid`, `instr_ready` high at T+2.
- `wb_ready` low for 5 cycles after `wb_valid` -> `wb_valid`, `wb_rd` and `wb_data` stable, and `instr_ready` low throughout. `rst_n` low during WB -> all outputs 0 and `instr_ready` 1.
- LUI x1,0x12345 (0x123450B7):
  - With `ALU_ISSUE_UTYPE_EN`: a = 0, b = 0x12345000, `wb_data` = 0x12345000.
  - Without it: illegal pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, RV32I opcode/funct7 constants and issue FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ops_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WB      = 3'd3,
    ERR     = 3'd4
  } issue_state_e;

  // alt selects SUB/SRA on the two funct3 values that have an alternate form
  function automatic alu_ops_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_ops_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - combinational RV32I ALU-class decode; LUI/AUIPC under ALU_ISSUE_UTYPE_EN
module alu_instr_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output alu_ops_e        op,
  output logic [4:0]      rd,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

`ifndef ALU_ISSUE_UTYPE_EN
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    a       = rs1_data;
    b       = rs2_data;
    op      = ALU_ADD;
    illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          illegal = 1'b0;
          op      = f3_to_op(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          illegal = 1'b0;
          op      = f3_to_op(funct3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        b = {{(XLEN-12){instr[31]}}, instr[31:20]};
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // shift immediates carry the SRA selector in the upper imm bits
          b = {{(XLEN-5){1'b0}}, instr[24:20]};
          if (funct7 == F7_BASE) begin
            illegal = 1'b0;
            op      = f3_to_op(funct3, 1'b0);
          end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
            illegal = 1'b0;
            op      = ALU_SRA;
          end
        end else begin
          illegal = 1'b0;
          op      = f3_to_op(funct3, 1'b0);
        end
      end
`ifdef ALU_ISSUE_UTYPE_EN
      OPC_LUI: begin
        illegal = 1'b0;
        a       = '0;
        b       = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        illegal = 1'b0;
        a       = pc;
        b       = {instr[31:12], 12'b0};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue/writeback sequencer; optional LUI/AUIPC via ALU_ISSUE_UTYPE_EN
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            alu_clk_enable,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op_select,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal_instr
);

  issue_state_e    state, state_n;
  logic [XLEN-1:0] dec_a, dec_b;
  alu_ops_e        dec_op;
  logic [4:0]      dec_rd;
  logic            dec_illegal;
  logic            accept;

  alu_instr_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .a        (dec_a),
    .b        (dec_b),
    .op       (dec_op),
    .rd       (dec_rd),
    .illegal  (dec_illegal)
  );

  assign accept = (state == IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // operands stay put until the next legal accept so the ALU sees stable inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op_select <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      if (accept && !dec_illegal) begin
        alu_a         <= dec_a;
        alu_b         <= dec_b;
        alu_op_select <= dec_op;
        wb_rd         <= dec_rd;
      end
      if (state == CAPTURE) begin
        wb_data <= alu_out;
      end
    end
  end

  always_comb begin
    state_n        = state;
    instr_ready    = 1'b0;
    alu_clk_enable = 1'b0;
    wb_valid       = 1'b0;
    illegal_instr  = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_n = dec_illegal ? ERR : ISSUE;
        end
      end
      ISSUE: begin
        alu_clk_enable = 1'b1;
        state_n        = CAPTURE;
      end
      CAPTURE: state_n = WB;
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_n = IDLE;
        end
      end
      ERR: begin
        illegal_instr = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a registered ALU stand-in
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        alu_clk_enable;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op_select;
  logic [31:0] alu_out = '0;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_instr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc             (pc),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .alu_clk_enable (alu_clk_enable),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op_select  (alu_op_select),
    .alu_out        (alu_out),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .illegal_instr  (illegal_instr)
  );

  // registered ALU: result appears the cycle after clk_enable
  always @(posedge clk) begin
    if (alu_clk_enable) begin
      case (alu_op_select)
        4'd0: alu_out <= alu_a + alu_b;
        4'd1: alu_out <= alu_a - alu_b;
        4'd2: alu_out <= {31'b0, $signed(alu_a) < $signed(alu_b)};
        4'd3: alu_out <= {31'b0, alu_a < alu_b};
        4'd4: alu_out <= alu_a ^ alu_b;
        4'd5: alu_out <= alu_a | alu_b;
        4'd6: alu_out <= alu_a & alu_b;
        4'd7: alu_out <= alu_a << alu_b[4:0];
        4'd8: alu_out <= alu_a >> alu_b[4:0];
        4'd9: alu_out <= $signed(alu_a) >>> alu_b[4:0];
        default: alu_out <= 32'hDEAD_BEEF;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer for one cycle; returns positioned in T+1
  task automatic offer(input logic [31:0] iw, input logic [31:0] r1, input logic [31:0] r2);
    instr       = iw;
    rs1_data    = r1;
    rs2_data    = r2;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  logic [31:0] hold_data;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    pc          = 32'h0000_1000;
    rs1_data    = '0;
    rs2_data    = '0;
    wb_ready    = 1'b1;
    step();
    step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_clk_en", alu_clk_enable, 0);
    rst_n = 1'b1;
    step();
    chk("rst_instr_ready", instr_ready, 1);

    // ADD x3,x1,x2
    offer(32'h002081B3, 32'd5, 32'd7);
    chk("add_clk_en_t1", alu_clk_enable, 1);
    chk("add_op", alu_op_select, 0);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_ready_t1", instr_ready, 0);
    step();
    chk("add_clk_en_t2", alu_clk_enable, 0);
    chk("add_wb_valid_t2", wb_valid, 0);
    step();
    chk("add_wb_valid_t3", wb_valid, 1);
    chk("add_wb_rd", wb_rd, 3);
    chk("add_wb_data", wb_data, 12);
    step();
    chk("add_wb_valid_t4", wb_valid, 0);
    chk("add_ready_t4", instr_ready, 1);
    chk("add_a_stable", alu_a, 5);

    // SUB x3,x1,x2
    offer(32'h402081B3, 32'd5, 32'd7);
    chk("sub_op", alu_op_select, 1);
    step();
    step();
    chk("sub_wb_data", wb_data, 32'hFFFF_FFFE);
    step();

    // SRAI x5,x6,4
    offer(32'h40435293, 32'h8000_0000, 32'h0);
    chk("srai_op", alu_op_select, 9);
    chk("srai_b", alu_b, 4);
    step();
    step();
    chk("srai_wb_rd", wb_rd, 5);
    chk("srai_wb_data", wb_data, 32'hF800_0000);
    step();

    // ADDI x1,x0,-1 with rs1=10: sign-extended immediate
    offer(32'hFFF00093, 32'd10, 32'd99);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    step();
    step();
    chk("addi_wb_data", wb_data, 9);
    step();

    // undefined opcode
    offer(32'h0000007F, 32'd1, 32'd2);
    chk("ill_pulse_t1", illegal_instr, 1);
    chk("ill_wb_valid_t1", wb_valid, 0);
    chk("ill_a_unchanged", alu_a, 10);
    step();
    chk("ill_pulse_t2", illegal_instr, 0);
    chk("ill_ready_t2", instr_ready, 1);
    chk("ill_wb_valid_t2", wb_valid, 0);

    // funct7 0100000 with funct3 001 on OP is not a legal encoding
    offer(32'h402091B3, 32'd1, 32'd2);
    chk("f7alt_sll_illegal", illegal_instr, 1);
    step();

    // writeback backpressure, then reset during WB
    wb_ready = 1'b0;
    offer(32'h002081B3, 32'd20, 32'd22);
    step();
    step();
    chk("bp_wb_valid_t3", wb_valid, 1);
    hold_data = wb_data;
    chk("bp_wb_data", hold_data, 42);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", wb_valid, 1);
      chk("bp_hold_rd", wb_rd, 3);
      chk("bp_hold_data", wb_data, 42);
      chk("bp_hold_ready", instr_ready, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstwb_wb_valid", wb_valid, 0);
    chk("rstwb_wb_data", wb_data, 0);
    chk("rstwb_wb_rd", wb_rd, 0);
    chk("rstwb_alu_b", alu_b, 0);
    chk("rstwb_op", alu_op_select, 0);
    chk("rstwb_ready", instr_ready, 1);
    step();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    step();

    // LUI x1,0x12345
    offer(32'h123450B7, 32'hAAAA_AAAA, 32'h5555_5555);
`ifdef ALU_ISSUE_UTYPE_EN
    chk("lui_illegal", illegal_instr, 0);
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'h1234_5000);
    step();
    step();
    chk("lui_wb_rd", wb_rd, 1);
    chk("lui_wb_data", wb_data, 32'h1234_5000);
    step();
`else
    chk("lui_illegal", illegal_instr, 1);
    chk("lui_wb_valid", wb_valid, 0);
    step();
    chk("lui_ready_t2", instr_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
